// File: rtl/buffer3_if.sv
// EX/MEM handshake bundle: EX-side inputs with in_valid/in_ready,
// MEM-side outputs with out_valid/out_ready.
interface buffer3_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] dr2;
    logic [DW-1:0] cuatro;
    logic [DW-1:0] sign;
    logic          zero;
    logic [RW-1:0] AW;
    logic          regwrite;
    logic          memtoreg;
    logic          er;
    logic          ew;
    logic          branch;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] dr2_out;
    logic [DW-1:0] target_out;
    logic [RW-1:0] out_AW;
    logic          out_regwrite;
    logic          out_memtoreg;
    logic          er_out;
    logic          ew_out;
    logic          out_pcsrc;

    modport master (
        output in_valid, alu_res, dr2, cuatro, sign, zero, AW,
        output regwrite, memtoreg, er, ew, branch, out_ready,
        input  in_ready, out_valid, alu_out, dr2_out, target_out,
        input  out_AW, out_regwrite, out_memtoreg, er_out, ew_out,
        input  out_pcsrc
    );

    modport slave (
        input  in_valid, alu_res, dr2, cuatro, sign, zero, AW,
        input  regwrite, memtoreg, er, ew, branch, out_ready,
        output in_ready, out_valid, alu_out, dr2_out, target_out,
        output out_AW, out_regwrite, out_memtoreg, er_out, ew_out,
        output out_pcsrc
    );
endinterface

// File: rtl/buffer3.sv
// EX/MEM pipeline register with 2-entry skid buffer and sync flush.
// Optional BUFFER3_PERF_EN adds a saturating 16-bit stall_cnt output.
module buffer3 #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
`ifdef BUFFER3_PERF_EN
    output logic [15:0] stall_cnt,
`endif
    buffer3_if.slave    bus
);
    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] dr2;
        logic [DW-1:0] tgt;
        logic [RW-1:0] aw;
        logic          rw;
        logic          m2r;
        logic          er;
        logic          ew;
        logic          pcsrc;
    } ent_t;

    ent_t main_q;
    ent_t skid_q;
    ent_t in_ent;
    logic main_v;
    logic skid_v;
    logic accept;
    logic drain;

    always_comb begin
        in_ent       = '0;
        in_ent.alu   = bus.alu_res;
        in_ent.dr2   = bus.dr2;
        in_ent.tgt   = bus.cuatro + (bus.sign << 2);
        in_ent.aw    = bus.AW;
        in_ent.rw    = bus.regwrite;
        in_ent.m2r   = bus.memtoreg;
        in_ent.er    = bus.er;
        in_ent.ew    = bus.ew;
        in_ent.pcsrc = bus.branch & bus.zero;
    end

    // in_ready depends only on skid_v, so MEM stalls never reach EX combinationally
    assign accept = bus.in_valid & ~skid_v;
    assign drain  = main_v & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v) begin
            if (accept) begin
                main_q <= in_ent;
                main_v <= 1'b1;
            end
        end else if (drain) begin
            if (skid_v) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= in_ent;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= in_ent;
            skid_v <= 1'b1;
        end
    end

    assign bus.in_ready     = ~skid_v;
    assign bus.out_valid    = main_v;
    assign bus.alu_out      = main_q.alu;
    assign bus.dr2_out      = main_q.dr2;
    assign bus.target_out   = main_q.tgt;
    assign bus.out_AW       = main_q.aw;
    assign bus.out_memtoreg = main_q.m2r;
    assign bus.out_regwrite = main_q.rw & main_v;
    assign bus.er_out       = main_q.er & main_v;
    assign bus.ew_out       = main_q.ew & main_v;
    assign bus.out_pcsrc    = main_q.pcsrc & main_v;

`ifdef BUFFER3_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (main_v && !bus.out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/buffer3.md
Name: buffer3

Overview:
- EX/MEM pipeline register. Sits directly downstream of the ID/EX register and the ALU, and feeds the data-memory stage.
- Captures the ALU result, store data, destination register and the memory/write-back control bits.
- Resolves the branch target and the pcsrc decision.
- Adds a 2-entry skid buffer with valid/ready handshake on both sides, plus a synchronous flush, so the memory stage can stall without combinational ready paths back into EX.

Parameters:
- DW, 32, datapath width (ALU result, store data, PC values).
- RW, 5, register-address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  EX stage presents a valid instruction.
- in_ready  out  1  buffer can accept this cycle.
- alu_res  in  DW  ALU result / memory address.
- dr2  in  DW  store data.
- cuatro  in  DW  PC+4 of the instruction.
- sign  in  DW  sign-extended immediate.
- zero  in  1  ALU zero flag.
- AW  in  RW  destination register (after regdst mux).
- regwrite, memtoreg, er, ew, branch  in  1 each  control bits.
- out_valid  out  1  memory stage holds a valid entry.
- out_ready  in  1  memory stage consumes this cycle.
- alu_out, dr2_out, target_out  out  DW  result, store data, branch target.
- out_AW  out  RW  destination register.
- out_regwrite, out_memtoreg, er_out, ew_out, out_pcsrc  out  1 each  gated controls.

Behaviour:
- Reset (rst_n=0, asynchronous): main/skid valids=0, all data/control registers=0, in_ready=1 after release, out_valid=0.
- Storage: main register (drives outputs) plus skid register. in_ready = ~skid_valid and is purely registered, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Target computed at capture: target = cuatro + (sign << 2), modulo 2^DW, wrap ignored.
- pcsrc computed at capture: pcsrc = branch & zero.
- Per-cycle transitions, main empty:
  - Accept loads main; out_valid=1 next cycle.
- Main full:
  - Drain without accept: skid moves to main if skid valid, else main empties.
  - Drain with accept (skid empty): new entry goes straight to main.
  - Accept without drain: new entry goes to skid; in_ready=0 next cycle.
  - Neither: hold.
- Skid full: in_ready=0, so no accept is possible. Drain moves skid to main and in_ready=1 next cycle.
- Order: strict FIFO, no reordering or duplication. Latency is 1 cycle when unstalled.
- Flush (synchronous) clears both valids next edge and overrides accept and drain in the same cycle; the input that cycle is discarded. Data registers may keep stale values.
- Output gating: out_regwrite, er_out, ew_out, out_pcsrc = stored value & out_valid. These are 0 whenever out_valid=0. Data outputs are ungated.
- Reset asserted mid-transfer drops all entries immediately.

Optional Feature:
- BUFFER3_PERF_EN defined: adds output port stall_cnt (16 bits).
  - Increments each cycle out_valid & ~out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- BUFFER3_PERF_EN undefined: no port, no counter logic.

Test Plan:
- Reset, then in_valid=1 with alu_res=32'h10, AW=5'd3, regwrite=1, out_ready=1 -> next cycle out_valid=1, alu_out=32'h10, out_AW=3, out_regwrite=1; in_ready stays 1.
- Branch: cuatro=32'h100, sign=32'hFFFFFFFF, branch=1, zero=1 -> target_out=32'hFC, out_pcsrc=1; same with zero=0 -> out_pcsrc=0.
- Backpressure: out_ready=0, push A then B -> out shows A, in_ready=0. Third push C is not accepted. Raise out_ready -> A, B, then C after re-offer, in order, none lost.
- Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, out_regwrite=ew_out=0; the flushed input never appears.
- Async reset asserted mid-stall between clock edges -> out_valid=0 immediately, without waiting for an edge.
- With BUFFER3_PERF_EN: hold out_ready=0 for 10 cycles with a valid entry -> stall_cnt=10. A flush leaves it at 10.
